imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the synchronous-read instruction ROM. That ROM registers its address on the clock edge and presents data one cycle later.
- Owns the PC and drives the ROM word address every cycle. Pairs each returned word with its PC and hands it to the IF/ID stage over a valid/ready handshake.
- Handles backpressure by replaying the address, and handles redirects (branch/jump) and halt.

---
 rtl/imem_fetch_ctrl.sv | 109 ++++++++++
 tb/tb_imem_fetch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : imem_fetch_ctrl
// Purpose : PC owner and fetch sequencer for a synchronous-read instruction ROM
// Revision: 1.0
// ============================================================================
module imem_fetch_ctrl #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  halt_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc,
  output logic                  out_fault,
  output logic                  halted
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_vld;

  logic [31:0] w_redir_pc;
  logic [31:0] w_fetch_pc;
  logic        w_run;
  logic        w_redirect;
  logic        w_halt_go;
  logic        w_advance;
  logic        w_unused;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign w_run      = (r_state == ST_RUN);
  assign w_redirect = redirect_valid & (r_state != ST_BOOT);
  assign w_halt_go  = w_run & ~redirect_valid & halt_req & (~r_vld | out_ready);
  assign w_advance  = w_run & ~redirect_valid & ~halt_req & r_vld & out_ready;
  assign w_unused   = ^redirect_pc[1:0];

  // The address presented this cycle is exactly the PC of the word that will
  // be on rom_data next cycle, so it doubles as the next pc value.
  always_comb begin
    w_fetch_pc = r_pc;
    if (r_state == ST_BOOT) begin
      w_fetch_pc = RESET_PC;
    end else if (w_redirect) begin
      w_fetch_pc = w_redir_pc;
    end else if (w_advance) begin
      w_fetch_pc = r_pc + 32'd4;
    end
  end

  assign rom_addr = w_fetch_pc[ADDR_WIDTH+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_vld   <= 1'b0;
    end else begin
      r_pc <= w_fetch_pc;
      case (r_state)
        ST_BOOT: begin
          r_vld   <= 1'b1;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_valid) begin
            r_vld <= 1'b1;
          end else if (w_halt_go) begin
            r_vld   <= 1'b0;
            r_state <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (redirect_valid) begin
            r_vld   <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_vld   <= 1'b0;
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign out_valid = w_run & r_vld & ~redirect_valid;
  assign out_pc    = r_pc;
  assign out_instr = rom_data;
  // Out-of-range words are still delivered via the aliased index; decode traps.
  assign out_fault = out_valid & (|r_pc[31:ADDR_WIDTH+2]);
  assign halted    = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_fetch_ctrl
// Purpose : Directed scoreboard bench for imem_fetch_ctrl
// Revision: 1.0
// ============================================================================
module tb_imem_fetch_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          halt_req;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [31:0]   out_pc;
  logic          out_fault;
  logic          halted;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  imem_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read ROM: ROM[i] = 0x1000_0000 + i
  always @(posedge clk) rom_data <= 32'h1000_0000 + {24'h0, rom_addr};

  // Monitor: every handshake must match the next expected transfer, in order
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL xfer_unexpected: got pc=%h instr=%h, expected no transfer", out_pc, out_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_pc !== mon_e.pc || out_instr !== mon_e.instr || out_fault !== mon_e.fault) begin
          n_err++;
          $display("FAIL xfer: got pc=%h instr=%h fault=%b, expected pc=%h instr=%h fault=%b",
                   out_pc, out_instr, out_fault, mon_e.pc, mon_e.instr, mon_e.fault);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    exp_t e;
    e.pc = pc; e.instr = instr; e.fault = fault;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic boot_stream();
    settle();
    chk("boot_valid", {31'h0, out_valid}, 32'h0);
    chk("boot_addr", {24'h0, rom_addr}, 32'h0);
    push(32'h0, 32'h1000_0000, 1'b0);
    push(32'h4, 32'h1000_0001, 1'b0);
    push(32'h8, 32'h1000_0002, 1'b0);
    cyc(); settle();
    chk("first_valid", {31'h0, out_valid}, 32'h1);
    chk("first_pc", out_pc, 32'h0);
    cyc(); cyc();
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; halt_req = 1'b0;
    cyc(); cyc(); settle();
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_fault", {31'h0, out_fault}, 32'h0);
    chk("rst_addr", {24'h0, rom_addr}, 32'h0);
    rst_n = 1'b1;

    // Boot streaming, then backpressure on pc 0x8
    boot_stream();
    out_ready = 1'b0;
    repeat (3) begin
      settle();
      chk("stall_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_pc", out_pc, 32'h8);
      chk("stall_instr", out_instr, 32'h1000_0002);
      chk("stall_addr", {24'h0, rom_addr}, 32'h2);
      cyc();
    end
    out_ready = 1'b1;
    push(32'hC, 32'h1000_0003, 1'b0);
    cyc(); cyc();

    // Redirect while 0x10 is valid
    chk("pre_redir_pc", out_pc, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    settle();
    chk("redir_valid", {31'h0, out_valid}, 32'h0);
    chk("redir_addr", {24'h0, rom_addr}, 32'h10);
    push(32'h40, 32'h1000_0010, 1'b0);
    cyc(); redirect_valid = 1'b0; settle();
    chk("redir_pc", out_pc, 32'h40);
    cyc();

    // Redirect during a stall on 0x44
    out_ready = 1'b0;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    settle();
    chk("stall_redir_valid", {31'h0, out_valid}, 32'h0);
    push(32'h40, 32'h1000_0010, 1'b0);
    cyc(); redirect_valid = 1'b0; out_ready = 1'b1; settle();
    chk("stall_redir_pc", out_pc, 32'h40);
    push(32'h44, 32'h1000_0011, 1'b0);
    push(32'h48, 32'h1000_0012, 1'b0);
    cyc(); cyc();

    // Halt requested while stalled waits for the transfer
    out_ready = 1'b0; halt_req = 1'b1;
    settle();
    chk("halt_pend_halted", {31'h0, halted}, 32'h0);
    cyc(); settle();
    chk("halt_wait_halted", {31'h0, halted}, 32'h0);
    chk("halt_wait_pc", out_pc, 32'h48);
    out_ready = 1'b1;
    cyc(); settle();
    chk("halted", {31'h0, halted}, 32'h1);
    chk("halted_valid", {31'h0, out_valid}, 32'h0);
    repeat (5) begin
      cyc(); settle();
      chk("hold_halted", {31'h0, halted}, 32'h1);
      chk("hold_valid", {31'h0, out_valid}, 32'h0);
      chk("hold_addr", {24'h0, rom_addr}, 32'h12);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    push(32'h20, 32'h1000_0008, 1'b0);
    cyc(); redirect_valid = 1'b0; halt_req = 1'b0; settle();
    chk("resume_halted", {31'h0, halted}, 32'h0);
    chk("resume_pc", out_pc, 32'h20);
    cyc();

    // Range edge and index wrap
    redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    push(32'h3FC, 32'h1000_00FF, 1'b0);
    push(32'h400, 32'h1000_0000, 1'b1);
    cyc(); redirect_valid = 1'b0; settle();
    chk("edge_fault", {31'h0, out_fault}, 32'h0);
    cyc(); settle();
    chk("wrap_fault", {31'h0, out_fault}, 32'h1);
    chk("wrap_instr", out_instr, 32'h1000_0000);
    cyc();

    // Asynchronous reset mid-stall, between edges
    out_ready = 1'b0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_pc", out_pc, 32'h0);
    chk("arst_halted", {31'h0, halted}, 32'h0);
    chk("arst_addr", {24'h0, rom_addr}, 32'h0);
    out_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    boot_stream();
    @(negedge clk);
    #1 out_ready = 1'b0;
    cyc();

    chk("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
